// File: rtl/sample_frame_ctrl.sv
// Frame-assembly controller: collects NUM_WORDS host words into a load buffer
// and commits them atomically to a registered frame with a valid/ready output.
// Ports:
//   clk, rst (async active-high), wr_en/wr_addr/wr_data (host writes,
//   addr NUM_WORDS is the command register), err_clr, frame_ready (in);
//   frame_data, frame_valid, fill_mask, busy, frame_count, err_sticky,
//   led_frame (out).
module sample_frame_ctrl #(
  parameter  int WORD_W    = 16,
  parameter  int NUM_WORDS = 20,
  localparam int FRAME_W   = WORD_W * NUM_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 err_clr,
  input  logic                 frame_ready,
  output logic [FRAME_W-1:0]   frame_data,
  output logic                 frame_valid,
  output logic [NUM_WORDS-1:0] fill_mask,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 err_sticky,
  output logic                 led_frame
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_OUT
  } state_t;

  state_t state, state_n;

  logic [FRAME_W-1:0]   load_buf;
  logic [NUM_WORDS-1:0] mask_n;

  logic data_wr, cmd_wr, bad_wr;
  logic abort, commit, full;
  logic out_free, accept, xfer;
  logic store, err_set;

  assign data_wr  = wr_en && (wr_addr <  5'(NUM_WORDS));
  assign cmd_wr   = wr_en && (wr_addr == 5'(NUM_WORDS));
  assign bad_wr   = wr_en && (wr_addr >  5'(NUM_WORDS));

  // Abort has priority over commit when both bits are set.
  assign abort    = cmd_wr && wr_data[1];
  assign commit   = cmd_wr && wr_data[0] && !wr_data[1];
  assign full     = &fill_mask;

  assign accept   = frame_valid && frame_ready;
  assign out_free = !frame_valid || frame_ready;

  // WAIT_OUT always holds a full mask, so it transfers as soon as the
  // output slot frees up.
  assign xfer     = !abort && out_free &&
                    ((state == WAIT_OUT) || (commit && full));

  assign store    = data_wr && (state != WAIT_OUT);

  assign err_set  = bad_wr ||
                    (data_wr && (state == WAIT_OUT)) ||
                    (commit && !full);

  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    mask_n  = fill_mask;
    if (abort || xfer) begin
      state_n = IDLE;
      mask_n  = '0;
    end else begin
      unique case (state)
        IDLE, FILL: begin
          if (store) begin
            state_n         = FILL;
            mask_n[wr_addr] = 1'b1;
          end else if (commit && full) begin
            state_n = WAIT_OUT;
          end
        end
        WAIT_OUT: state_n = WAIT_OUT;
        default:  state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_buf  <= '0;
      fill_mask <= '0;
    end else begin
      fill_mask <= mask_n;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (store && (wr_addr == 5'(i)))
          load_buf[i*WORD_W +: WORD_W] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      led_frame   <= 1'b0;
    end else begin
      if (xfer) begin
        frame_data  <= load_buf;
        frame_valid <= 1'b1;
      end else if (accept) begin
        frame_valid <= 1'b0;
      end
      if (accept) begin
        frame_count <= frame_count + 16'd1;
        led_frame   <= ~led_frame;
      end
    end
  end

  // A new error outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Directed self-checking bench for sample_frame_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sample_frame_ctrl;

  localparam int WW = 16;
  localparam int NW = 20;
  localparam int FW = WW * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          err_clr = 1'b0;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic [NW-1:0] fill_mask;
  logic          busy;
  logic [15:0]   frame_count;
  logic          err_sticky;
  logic          led_frame;

  int n_chk  = 0;
  int n_fail = 0;
  logic led_exp = 1'b0;

  logic [FW-1:0] exp1, exp2, exp3, exp5, exp6;

  sample_frame_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .err_clr     (err_clr),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .fill_mask   (fill_mask),
    .busy        (busy),
    .frame_count (frame_count),
    .err_sticky  (err_sticky),
    .led_frame   (led_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [FW-1:0] obs,
                     input logic [FW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int base);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NW; i++) f[i*WW +: WW] = 16'(base + i);
    return f;
  endfunction

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = 16'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) wr(i, base + i);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    exp1 = mk(16'h0000);
    exp2 = mk(16'h0100);
    exp3 = mk(16'h0200);
    exp5 = mk(16'h0500);
    exp6 = mk(16'h0600);

    idle(); idle();
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_data", frame_data, {FW{1'b0}});
    chk("rst_mask", fill_mask, 20'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", frame_count, 16'h0);
    chk("rst_err", err_sticky, 1'b0);
    chk("rst_led", led_frame, 1'b0);
    rst = 1'b0;
    idle();

    wr(0, 0);
    chk("f1_mask1", fill_mask, 20'h00001);
    chk("f1_busy1", busy, 1'b1);
    for (int i = 1; i < NW; i++) wr(i, i);
    chk("f1_maskfull", fill_mask, 20'hFFFFF);
    wr(NW, 1);
    chk("f1_valid", frame_valid, 1'b1);
    chk("f1_data", frame_data, exp1);
    chk("f1_mask0", fill_mask, 20'h0);
    chk("f1_busy0", busy, 1'b0);
    chk("f1_err", err_sticky, 1'b0);

    fill(16'h0100, NW);
    wr(NW, 1);
    chk("f2_busy_wait", busy, 1'b1);
    idle();
    chk("f2_hold_data", frame_data, exp1);
    wr(3, 16'hDEAD);
    chk("wait_wr_err", err_sticky, 1'b1);
    err_clr = 1'b1;
    wr(25, 16'h1234);
    err_clr = 1'b0;
    chk("clr_vs_err", err_sticky, 1'b1);
    idle();
    chk("f2_still_busy", busy, 1'b1);
    chk("f2_still_valid", frame_valid, 1'b1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("err_clr1", err_sticky, 1'b0);
    frame_ready = 1'b1;
    idle();
    frame_ready = 1'b0;
    led_exp = ~led_exp;
    chk("f2_count", frame_count, 16'd1);
    chk("f2_valid", frame_valid, 1'b1);
    chk("f2_data", frame_data, exp2);
    chk("f2_busy0", busy, 1'b0);
    chk("f2_led", led_frame, led_exp);

    fill(16'h0200, NW - 1);
    wr(NW, 1);
    chk("part_err", err_sticky, 1'b1);
    chk("part_mask", fill_mask, 20'h7FFFF);
    chk("part_busy", busy, 1'b1);
    chk("part_data", frame_data, exp2);
    wr(NW - 1, 16'h0200 + NW - 1);
    frame_ready = 1'b1;
    wr(NW, 1);
    frame_ready = 1'b0;
    led_exp = ~led_exp;
    chk("f3_count", frame_count, 16'd2);
    chk("f3_valid", frame_valid, 1'b1);
    chk("f3_data", frame_data, exp3);
    chk("f3_busy", busy, 1'b0);
    chk("f3_mask", fill_mask, 20'h0);
    chk("f3_led", led_frame, led_exp);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("err_clr2", err_sticky, 1'b0);

    wr(25, 16'h5555);
    chk("bad_addr_err", err_sticky, 1'b1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    fill(16'h0300, 10);
    chk("ab_mask10", fill_mask, 20'h003FF);
    wr(NW, 3);
    chk("ab_mask", fill_mask, 20'h0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_err", err_sticky, 1'b0);
    chk("ab_data", frame_data, exp3);

    fill(16'h0400, NW);
    wr(NW, 1);
    chk("ab2_wait", busy, 1'b1);
    wr(NW, 2);
    chk("ab2_busy", busy, 1'b0);
    chk("ab2_valid", frame_valid, 1'b1);
    chk("ab2_data", frame_data, exp3);
    chk("ab2_mask", fill_mask, 20'h0);

    frame_ready = 1'b1;
    idle();
    led_exp = ~led_exp;
    chk("f3_drain_valid", frame_valid, 1'b0);
    chk("f3_drain_count", frame_count, 16'd3);
    chk("f3_drain_led", led_frame, led_exp);

    force dut.frame_count = 16'hFFFE;
    #1;
    release dut.frame_count;
    fill(16'h0500, NW);
    wr(NW, 1);
    chk("f5_data", frame_data, exp5);
    chk("f5_valid", frame_valid, 1'b1);
    idle();
    led_exp = ~led_exp;
    chk("f5_count", frame_count, 16'hFFFF);
    chk("f5_led", led_frame, led_exp);
    chk("f5_valid0", frame_valid, 1'b0);
    fill(16'h0600, NW);
    wr(NW, 1);
    chk("f6_data", frame_data, exp6);
    idle();
    led_exp = ~led_exp;
    chk("wrap_count", frame_count, 16'h0000);
    chk("wrap_led", led_frame, led_exp);
    frame_ready = 1'b0;

    fill(16'h0700, 5);
    chk("mid_mask", fill_mask, 20'h0001F);
    rst = 1'b1;
    #1;
    chk("mr_mask", fill_mask, 20'h0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_valid", frame_valid, 1'b0);
    chk("mr_data", frame_data, {FW{1'b0}});
    chk("mr_count", frame_count, 16'h0);
    chk("mr_led", led_frame, 1'b0);
    chk("mr_err", err_sticky, 1'b0);
    idle();
    rst = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
